vga_fb_swap_ctrl: RTL and testbench
===================================

Name: vga_fb_swap_ctrl

Overview:
- Double-buffer controller that sits directly upstream of the VGA display driver.
- Holds front/back framebuffer base addresses and drives the driver's framebuffer-address input.
- On a software swap request it waits for the driver's end-of-frame pulse, then swaps buffers.
- Optionally clears the new back buffer to a solid RGB555 colour through an Avalon-MM write master.

Parameters:
FB_WORDS, 240000, 32-bit words per framebuffer (800x600 pixels, two 16-bit pixels per word); must be >= 1
CNT_W, 18, width of the clear word counter; must satisfy 2^CNT_W > FB_WORDS

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
enable  input  1  level; 0 forces fb_addr to 0 so the display driver stalls
buf_a_base  input  32  byte base address of buffer A, word aligned
buf_b_base  input  32  byte base address of buffer B, word aligned
swap_req  input  1  one-cycle request to swap at the next end of frame
clear_en  input  1  sampled with swap_req; 1 = clear the new back buffer after the swap
fill_color  input  15  RGB555 clear colour, sampled with swap_req
frame_finished  input  1  one-cycle pulse from the display driver when the visible frame is finished
fb_addr  output  32  front buffer base address fed to the display driver
back_addr  output  32  back buffer base address (drawing target)
busy  output  1  high from an accepted swap_req until the swap (and clear) completes
swap_done  output  1  one-cycle completion pulse
master_address  output  32  Avalon byte address
master_write  output  1  Avalon write
master_writedata  output  32  Avalon write data
master_byteenable  output  4  always 4'hF
master_wait_request  input  1  Avalon wait request

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: fb_addr=0, back_addr=0, busy=0, swap_done=0, master_write=0, master_address=0, master_writedata=0. Internal state: front_sel=0 (A is front), state=IDLE, counter=0.
- Address outputs, updated every cycle:
  - fb_addr <= enable ? (front_sel ? buf_b_base : buf_a_base) : 0.
  - back_addr <= front_sel ? buf_a_base : buf_b_base.
- States: IDLE, WAIT_VBL, CLEAR, DONE.
- IDLE:
  - swap_req=1: latch clear_en, fill_color and the current back base into clr_base. Set busy=1. Go to WAIT_VBL.
  - frame_finished is ignored in IDLE.
  - If swap_req and frame_finished arrive in the same cycle, that frame_finished is not used; the block waits for the next one.
- WAIT_VBL:
  - On frame_finished: toggle front_sel. fb_addr shows the new front buffer on the following cycle.
  - Then go to CLEAR (counter=0) if latched clear_en=1, otherwise go to DONE.
  - Stays in WAIT_VBL indefinitely with busy=1.
- CLEAR:
  - master_write=1, master_address = clr_base + 4*counter, master_writedata = {1'b0, fill, 1'b0, fill}.
  - A word is accepted in a cycle where master_write=1 and master_wait_request=0; the counter then increments.
  - While master_wait_request=1, address and data are held stable.
  - After the word at counter = FB_WORDS-1 is accepted: master_write=0 on the next cycle, go to DONE.
  - Exactly FB_WORDS writes per clear, with no gaps forced by the block.
- DONE: swap_done=1 for exactly one cycle, busy=0 from this cycle, return to IDLE.
- swap_req while busy=1 is ignored and not queued.
- enable=0 during operation: the state machine keeps running; only fb_addr is forced to 0.
- Base inputs must be held stable while busy=1. The clear always uses the latched clr_base.
- Reset mid-CLEAR: master_write=0 and all outputs return to reset values on the next edge; the partial clear is abandoned.
- Arithmetic: the address sum is 32-bit and wraps modulo 2^32; no overflow detection.

Test Plan:
- Reset asserted 3 cycles with master_wait_request=1 -> all outputs 0, busy=0, no master_write.
- enable=1, buf_a_base=0x10000000, buf_b_base=0x10100000 -> one cycle later fb_addr=0x10000000 and back_addr=0x10100000; enable=0 -> fb_addr=0 on the next cycle.
- swap_req with clear_en=0, frame_finished 20 cycles later -> busy high for those cycles; fb_addr=0x10100000 and back_addr=0x10000000 one cycle after the pulse; swap_done one cycle; busy low.
- FB_WORDS=8, swap_req with clear_en=1 and fill_color=15'h7C00, random master_wait_request -> exactly 8 accepted writes to 0x10000000..0x1000001C step 4; data 0x7C007C00; byteenable 4'hF; address/data stable across waits; swap_done one cycle after the last accept.
- swap_req during WAIT_VBL or CLEAR, plus frame_finished during IDLE -> no extra swap, no extra swap_done, front_sel unchanged.
- reset asserted after the 3rd accepted clear write -> master_write=0 next cycle, fb_addr=0, busy=0; a fresh swap then completes normally.

Source files
------------

// File: rtl/vga_fb_swap_ctrl.sv
// Double-buffer controller for the VGA display driver: swaps front/back framebuffers
// at end of frame and optionally clears the new back buffer via an Avalon-MM write master.
module vga_fb_swap_ctrl #(
    parameter int FB_WORDS = 240000,
    parameter int CNT_W    = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] buf_a_base,
    input  logic [31:0] buf_b_base,
    input  logic        swap_req,
    input  logic        clear_en,
    input  logic [14:0] fill_color,
    input  logic        frame_finished,
    output logic [31:0] fb_addr,
    output logic [31:0] back_addr,
    output logic        busy,
    output logic        swap_done,
    output logic [31:0] master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic [3:0]  master_byteenable,
    input  logic        master_wait_request
);

    typedef enum logic [1:0] {IDLE, WAIT_VBL, CLEAR, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FB_WORDS - 1);

    state_t           state;
    logic             front_sel;
    logic             clr_pend;
    logic [14:0]      fill_q;
    logic [31:0]      clr_base;
    logic [CNT_W-1:0] counter;
    logic [31:0]      next_off;

    // Byte offset of the word after the one currently on the bus.
    always_comb begin
        next_off = (32'(counter) + 32'd1) << 2;
    end

    assign master_byteenable = 4'hF;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            front_sel        <= 1'b0;
            clr_pend         <= 1'b0;
            fill_q           <= '0;
            clr_base         <= '0;
            counter          <= '0;
            fb_addr          <= '0;
            back_addr        <= '0;
            busy             <= 1'b0;
            swap_done        <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            fb_addr   <= enable ? (front_sel ? buf_b_base : buf_a_base) : 32'd0;
            back_addr <= front_sel ? buf_a_base : buf_b_base;
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A frame_finished arriving with swap_req is deliberately not used.
                    if (swap_req) begin
                        clr_pend <= clear_en;
                        fill_q   <= fill_color;
                        clr_base <= front_sel ? buf_a_base : buf_b_base;
                        busy     <= 1'b1;
                        state    <= WAIT_VBL;
                    end
                end
                WAIT_VBL: begin
                    if (frame_finished) begin
                        front_sel <= ~front_sel;
                        if (clr_pend) begin
                            counter          <= '0;
                            master_write     <= 1'b1;
                            master_address   <= clr_base;
                            master_writedata <= {1'b0, fill_q, 1'b0, fill_q};
                            state            <= CLEAR;
                        end else begin
                            swap_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    // Address/data only move on an accepted word, so they hold across waits.
                    if (!master_wait_request) begin
                        if (counter == LAST) begin
                            master_write <= 1'b0;
                            swap_done    <= 1'b1;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            counter        <= counter + 1'b1;
                            master_address <= clr_base + next_off;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_swap_ctrl.sv
// Scoreboard bench for vga_fb_swap_ctrl: stimulus pushes expected writes/swaps,
// a negedge monitor pops and compares as the DUT presents them.
module tb_vga_fb_swap_ctrl;

    localparam logic [31:0] BA = 32'h1000_0000;
    localparam logic [31:0] BB = 32'h1010_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] buf_a_base = '0;
    logic [31:0] buf_b_base = '0;
    logic        swap_req = 1'b0;
    logic        clear_en = 1'b0;
    logic [14:0] fill_color = '0;
    logic        frame_finished = 1'b0;
    logic [31:0] fb_addr, back_addr, master_address, master_writedata;
    logic        busy, swap_done, master_write;
    logic [3:0]  master_byteenable;
    logic        master_wait_request = 1'b1;

    logic wr_rand = 1'b0;
    logic wr_fixed = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic [31:0] fb; logic [31:0] back; logic clr; } sw_t;
    wr_t wq[$];
    sw_t sq[$];

    vga_fb_swap_ctrl #(.FB_WORDS(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .buf_a_base(buf_a_base), .buf_b_base(buf_b_base),
        .swap_req(swap_req), .clear_en(clear_en), .fill_color(fill_color),
        .frame_finished(frame_finished),
        .fb_addr(fb_addr), .back_addr(back_addr), .busy(busy), .swap_done(swap_done),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_byteenable(master_byteenable),
        .master_wait_request(master_wait_request)
    );

    always #5 clk = ~clk;

    // Wait request changes just after the rising edge so it is stable at negedge sampling.
    always @(posedge clk) begin
        #1;
        master_wait_request = wr_rand ? 1'($urandom_range(0, 1)) : wr_fixed;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic push_clear(input logic [31:0] base, input logic [14:0] c, input int n);
        for (int i = 0; i < n; i++)
            wq.push_back('{a: base + 32'(4 * i), d: {1'b0, c, 1'b0, c}});
    endtask

    // Monitor
    int ncyc = 0;
    int last_acc = -10;
    logic pw = 1'b0, pwait = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    logic pend = 1'b0;
    sw_t  pend_sw;

    always @(negedge clk) begin
        wr_t w;
        sw_t s;
        ncyc++;
        if (master_write && pw && pwait) begin
            chk("hold_addr", master_address, pa);
            chk("hold_data", master_writedata, pd);
        end
        if (master_write && !master_wait_request) begin
            if (wq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL extra_write: got addr %h want none", master_address);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", master_address, w.a);
                chk("wr_data", master_writedata, w.d);
                chk("wr_be", 32'(master_byteenable), 32'hF);
            end
            last_acc = ncyc;
        end
        if (pend) begin
            chk("swap_fb", fb_addr, pend_sw.fb);
            chk("swap_back", back_addr, pend_sw.back);
            pend = 1'b0;
        end
        if (swap_done) begin
            if (sq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL extra_swap_done: got 1 want 0 at cycle %0d", ncyc);
            end else begin
                s = sq.pop_front();
                if (s.clr) chk("done_after_last", 32'(ncyc - last_acc), 32'd1);
                chk("done_no_write", 32'(master_write), 32'd0);
                pend_sw = s;
                pend = 1'b1;
            end
        end
        pw = master_write; pwait = master_wait_request;
        pa = master_address; pd = master_writedata;
    end

    initial begin
        int acc, k;
        // Reset with wait request high
        cyc(3);
        chk("rst_fb", fb_addr, 0);
        chk("rst_back", back_addr, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(swap_done), 0);
        chk("rst_write", 32'(master_write), 0);
        chk("rst_addr", master_address, 0);
        chk("rst_data", master_writedata, 0);
        reset = 1'b0; wr_fixed = 1'b0;

        // Address outputs and enable gating
        enable = 1'b1; buf_a_base = BA; buf_b_base = BB;
        cyc(1);
        chk("fb_a", fb_addr, BA);
        chk("back_b", back_addr, BB);
        enable = 1'b0;
        cyc(1);
        chk("fb_dis", fb_addr, 0);
        chk("back_dis", back_addr, BB);
        enable = 1'b1;
        cyc(1);

        // Plain swap, no clear
        sq.push_back('{fb: BB, back: BA, clr: 1'b0});
        swap_req = 1'b1; clear_en = 1'b0;
        cyc(1);
        swap_req = 1'b0;
        repeat (20) begin
            chk("busy_wait", 32'(busy), 1);
            cyc(1);
        end
        chk("fb_before", fb_addr, BA);
        frame_finished = 1'b1;
        cyc(1);
        frame_finished = 1'b0;
        chk("done_pulse", 32'(swap_done), 1);
        chk("busy_low", 32'(busy), 0);
        cyc(1);
        chk("done_one", 32'(swap_done), 0);
        cyc(3);

        // Frame end in IDLE is ignored
        frame_finished = 1'b1;
        cyc(1);
        frame_finished = 1'b0;
        cyc(3);
        chk("idle_ff_fb", fb_addr, BB);

        // Clear swap; the coincident frame_finished must not be used
        push_clear(BA, 15'h7C00, 8);
        sq.push_back('{fb: BA, back: BB, clr: 1'b1});
        swap_req = 1'b1; clear_en = 1'b1; fill_color = 15'h7C00; frame_finished = 1'b1;
        cyc(1);
        swap_req = 1'b0; clear_en = 1'b0; fill_color = '0; frame_finished = 1'b0;
        cyc(3);
        chk("still_wait", 32'(busy), 1);
        chk("no_early_wr", 32'(master_write), 0);
        chk("no_early_fb", fb_addr, BB);
        swap_req = 1'b1;
        cyc(1);
        swap_req = 1'b0;
        wr_rand = 1'b1;
        frame_finished = 1'b1;
        cyc(1);
        frame_finished = 1'b0;
        cyc(2);
        swap_req = 1'b1;
        cyc(1);
        swap_req = 1'b0;
        wait_idle("clear_done");
        wr_rand = 1'b0;
        cyc(6);
        chk("no_extra_busy", 32'(busy), 0);
        chk("after_clr_fb", fb_addr, BA);
        chk("clr_q_empty", 32'(wq.size()), 0);

        // Reset after the 3rd accepted clear word
        push_clear(BB, 15'h001F, 3);
        swap_req = 1'b1; clear_en = 1'b1; fill_color = 15'h001F;
        cyc(1);
        swap_req = 1'b0; clear_en = 1'b0;
        cyc(2);
        wr_rand = 1'b1;
        frame_finished = 1'b1;
        cyc(1);
        frame_finished = 1'b0;
        acc = 0; k = 0;
        while (acc < 3 && k < 400) begin
            if (master_write && !master_wait_request) acc++;
            if (acc < 3) begin
                @(negedge clk);
                k++;
            end
        end
        chk("three_acc", 32'(acc), 3);
        reset = 1'b1; wr_rand = 1'b0;
        cyc(1);
        chk("mid_rst_write", 32'(master_write), 0);
        chk("mid_rst_fb", fb_addr, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        chk("post_rst_fb", fb_addr, BA);

        // Fresh swap after reset: A is front again
        push_clear(BB, 15'h03E0, 8);
        sq.push_back('{fb: BB, back: BA, clr: 1'b1});
        swap_req = 1'b1; clear_en = 1'b1; fill_color = 15'h03E0;
        cyc(1);
        swap_req = 1'b0; clear_en = 1'b0;
        cyc(2);
        frame_finished = 1'b1;
        cyc(1);
        frame_finished = 1'b0;
        wait_idle("fresh_done");
        cyc(4);
        chk("wq_empty", 32'(wq.size()), 0);
        chk("sq_empty", 32'(sq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
